simon_decrypt_ctrl: RTL and testbench
=====================================

Name: simon_decrypt_ctrl

Overview:
Sequencer for the simon_decrypt round datapath. It accepts a 24-nibble ciphertext+key stream over a valid/ready interface and shifts it into the datapath. It then runs the datapath for exactly NUM_ROUNDS rounds and drains the 8-nibble result over a valid/ready output. It sits between the host pin interface and the datapath and owns the datapath's shift and advance-enable controls.

Parameters:
NUM_ROUNDS, 32, datapath round cycles per block; legal range 1..63.
LOAD_NIBBLES, 24, nibbles shifted in per block (8 data + 16 key); fixed by datapath width.
OUT_NIBBLES, 8, nibbles drained per block (32-bit round register).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  host nibble valid.
in_ready  output  1  controller can accept a nibble.
in_data  input  4  host nibble. Order: data nibbles LS-first (y[3:0] first), then key nibbles LS-first.
out_valid  output  1  result nibble valid.
out_ready  input  1  host accepts result nibble.
out_data  output  4  result nibble, LS-first.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse after the last result handshake.
dp_en  output  1  datapath register advance enable; the datapath holds state when 0.
dp_shift  output  1  datapath shift mode.
dp_data_in  output  4  nibble into the datapath.
dp_data_out  input  4  datapath round[3:0].

Behaviour:
- Reset is synchronous, active-high. State = IDLE, counters = 0, done = 0.
- While rst = 1: dp_en = 0, in_ready = 0, out_valid = 0.
- States: IDLE, LOAD, RUN, DRAIN. The state and 6-bit count are the only registers besides done.
- dp_en, dp_shift, dp_data_in and out_data are combinational from the state, the handshakes and dp_data_out.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: dp_en = 1, dp_shift = 1, dp_data_in = in_data; count <= 1; go to LOAD.
  - Otherwise dp_en = 0.
- LOAD:
  - in_ready = 1. Each handshake pulses dp_en = 1, dp_shift = 1, dp_data_in = in_data, and count++.
  - No handshake: dp_en = 0 and the datapath holds. Input gaps of any length are legal.
  - On the handshake where count = LOAD_NIBBLES-1: count <= 0; go to RUN.
- RUN:
  - in_ready = 0, dp_en = 1, dp_shift = 0 every cycle; count++.
  - After exactly NUM_ROUNDS cycles (count = NUM_ROUNDS-1): count <= 0; go to DRAIN.
  - Round cycles are never stalled.
- DRAIN:
  - out_valid = 1, out_data = dp_data_out.
  - On out_valid & out_ready: dp_en = 1, dp_shift = 1, dp_data_in = 4'h0, count++.
  - Without out_ready: dp_en = 0 and out_data is held stable.
  - On the handshake where count = OUT_NIBBLES-1: go to IDLE and set done <= 1 for one cycle.
  - The key register is destroyed by the drain; a new key must be loaded for every block.
- Handshake boundaries:
  - in_ready = 0 in RUN and DRAIN; in_valid there is ignored (no implicit capture).
  - out_valid = 0 outside DRAIN.
  - The first in_ready after DRAIN is the cycle after the last out handshake, never the same cycle.
- dp_shift = 0 whenever dp_en = 0.
- busy = 1 in LOAD, RUN and DRAIN.
- Block latency with no stalls: 24 load + NUM_ROUNDS run + 8 drain cycles; done rises 1 cycle after the last drain cycle.
- Reset mid-operation (any state): next cycle is IDLE with counts cleared. Datapath contents are stale but harmless, since the next LOAD fully overwrites them.

Test Plan:
- Reset then idle 10 cycles, in_valid = 0 -> in_ready = 1, busy = 0, dp_en = 0, out_valid = 0, done = 0 throughout.
- Back-to-back load of nibbles 0x0..0xF, 0x0..0x7 -> dp_data_in matches the sequence exactly. 24 dp_en & dp_shift cycles, then exactly 32 cycles of dp_en = 1, dp_shift = 0, then out_valid = 1.
- Load with in_valid toggling every other cycle -> dp_en pulses only on handshake cycles. The RUN phase still starts after exactly the 24th accepted nibble.
- All-zero ciphertext and key, out_ready low for 5 cycles in DRAIN -> out_data stable at 0x0 while stalled, dp_en = 0. After release, 8 nibbles of 0x0 are drained, then done pulses for 1 cycle and busy = 0.
- Random ciphertext/key versus a golden datapath+controller model with NUM_ROUNDS = 32 and NUM_ROUNDS = 1 -> drained nibbles match the model bit-exactly.
- rst asserted at RUN cycle 10, then a fresh 24-nibble block -> state is IDLE the cycle after rst. The second block runs the full 32 rounds, and its output equals a standalone run of that block.

Source files
------------

// File: rtl/simon_decrypt_ctrl.sv
// Sequencer for the simon_decrypt round datapath: loads a 24-nibble
// ciphertext+key block, runs NUM_ROUNDS round cycles, then drains the
// 8-nibble result. Owns the datapath advance-enable and shift controls.
module simon_decrypt_ctrl #(
  parameter int NUM_ROUNDS   = 32,
  parameter int LOAD_NIBBLES = 24,
  parameter int OUT_NIBBLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       busy,
  output logic       done,
  output logic       dp_en,
  output logic       dp_shift,
  output logic [3:0] dp_data_in,
  input  logic [3:0] dp_data_out
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  localparam logic [5:0] LOAD_LAST = 6'(LOAD_NIBBLES - 1);
  localparam logic [5:0] RUN_LAST  = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] OUT_LAST  = 6'(OUT_NIBBLES - 1);

  state_t     state, state_nx;
  logic [5:0] count, count_nx;
  logic       done_nx;

  // State, phase counter and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      done  <= done_nx;
    end
  end

  // Next state plus datapath/handshake controls; reset forces every
  // handshake and the datapath enable low so nothing is captured.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    done_nx    = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    dp_en      = 1'b0;
    dp_shift   = 1'b0;
    dp_data_in = 4'h0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dp_en      = 1'b1;
          dp_shift   = 1'b1;
          dp_data_in = in_data;
          count_nx   = 6'd1;
          state_nx   = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dp_en      = 1'b1;
          dp_shift   = 1'b1;
          dp_data_in = in_data;
          if (count == LOAD_LAST) begin
            count_nx = '0;
            state_nx = RUN;
          end else begin
            count_nx = count + 6'd1;
          end
        end
      end
      RUN: begin
        // Rounds are never stalled: the datapath advances every cycle.
        dp_en = 1'b1;
        if (count == RUN_LAST) begin
          count_nx = '0;
          state_nx = DRAIN;
        end else begin
          count_nx = count + 6'd1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Shifting zeros in exposes the next result nibble and wipes the key.
          dp_en    = 1'b1;
          dp_shift = 1'b1;
          if (count == OUT_LAST) begin
            count_nx = '0;
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            count_nx = count + 6'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      dp_en     = 1'b0;
      dp_shift  = 1'b0;
    end
  end

  // The datapath holds while dp_en is low, so the drained nibble stays stable.
  assign out_data = dp_data_out;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_simon_decrypt_ctrl.sv
// Directed bench for simon_decrypt_ctrl: two controllers (32 rounds and
// 1 round) each drive a behavioural datapath model; results are checked
// against a reference computation of load/round/drain.
`timescale 1ns/1ps
module tb_simon_decrypt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      in_valid, in_ready, out_valid, out_ready, busy, done, dp_en, dp_shift;
  logic [1:0][3:0] in_data, out_data, dp_data_in, dp_data_out;
  int total = 0;
  int bad   = 0;

  simon_decrypt_ctrl #(.NUM_ROUNDS(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .done(done[0]),
    .dp_en(dp_en[0]), .dp_shift(dp_shift[0]),
    .dp_data_in(dp_data_in[0]), .dp_data_out(dp_data_out[0])
  );

  simon_decrypt_ctrl #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .done(done[1]),
    .dp_en(dp_en[1]), .dp_shift(dp_shift[1]),
    .dp_data_in(dp_data_in[1]), .dp_data_out(dp_data_out[1])
  );

  // Simon-style round on {key[63:0], x[15:0], y[15:0]}; key rotates by a word.
  function automatic logic [95:0] rnd(input logic [95:0] r);
    logic [15:0] x, y, f;
    logic [63:0] k;
    x = r[31:16];
    y = r[15:0];
    k = r[95:32];
    f = ({y[14:0], y[15]} & {y[7:0], y[15:8]}) ^ {y[13:0], y[15:14]};
    return {k[15:0], k[63:16], y, x ^ f ^ k[15:0]};
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] d, input logic [63:0] k, input int nr);
    logic [95:0] r;
    r = {k, d};
    for (int i = 0; i < nr; i++) r = rnd(r);
    return r[31:0];
  endfunction

  // Datapath models: shift nibbles in at the top, round otherwise.
  logic [95:0] dpr0, dpr1;
  always_ff @(posedge clk) begin
    if (dp_en[0]) dpr0 <= dp_shift[0] ? {dp_data_in[0], dpr0[95:4]} : rnd(dpr0);
    if (dp_en[1]) dpr1 <= dp_shift[1] ? {dp_data_in[1], dpr1[95:4]} : rnd(dpr1);
  end
  assign dp_data_out[0] = dpr0[3:0];
  assign dp_data_out[1] = dpr1[3:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One block: load (optionally every other cycle), run, drain with an
  // optional stall. abort_at >= 0 pulses rst at that RUN cycle and returns.
  task automatic do_block(input int s, input logic [31:0] d, input logic [63:0] k,
                          input int nr, input bit toggle, input int stall,
                          input int abort_at, input string tg);
    logic [3:0]  nib [24];
    logic [31:0] exp;
    int i, ph, j;
    for (int n = 0; n < 8; n++)  nib[n]   = d[4*n +: 4];
    for (int n = 0; n < 16; n++) nib[8+n] = k[4*n +: 4];
    exp = golden(d, k, nr);
    i = 0;
    ph = 0;
    while (i < 24) begin
      tick;
      if (toggle && ph[0]) begin
        in_valid[s] = 1'b0;
        in_data[s]  = 4'hA;
        #1;
        chk($sformatf("%s.gap_en", tg), dp_en[s], 0);
        chk($sformatf("%s.gap_sh", tg), dp_shift[s], 0);
        chk($sformatf("%s.gap_busy", tg), busy[s], 1);
      end else begin
        in_valid[s] = 1'b1;
        in_data[s]  = nib[i];
        #1;
        chk($sformatf("%s.ld_rdy%0d", tg, i), in_ready[s], 1);
        chk($sformatf("%s.ld_en%0d", tg, i), dp_en[s], 1);
        chk($sformatf("%s.ld_sh%0d", tg, i), dp_shift[s], 1);
        chk($sformatf("%s.ld_din%0d", tg, i), dp_data_in[s], nib[i]);
        chk($sformatf("%s.ld_busy%0d", tg, i), busy[s], (i > 0) ? 1 : 0);
        i++;
      end
      ph++;
    end
    for (int r = 0; r < nr; r++) begin
      tick;
      in_valid[s] = 1'b1;
      in_data[s]  = 4'($urandom);
      #1;
      chk($sformatf("%s.run_rdy%0d", tg, r), in_ready[s], 0);
      chk($sformatf("%s.run_en%0d", tg, r), dp_en[s], 1);
      chk($sformatf("%s.run_sh%0d", tg, r), dp_shift[s], 0);
      chk($sformatf("%s.run_ov%0d", tg, r), out_valid[s], 0);
      if (abort_at == r) begin
        rst = 1'b1;
        in_valid[s] = 1'b0;
        #1;
        chk($sformatf("%s.rst_en", tg), dp_en[s], 0);
        chk($sformatf("%s.rst_rdy", tg), in_ready[s], 0);
        chk($sformatf("%s.rst_ov", tg), out_valid[s], 0);
        tick;
        rst = 1'b0;
        #1;
        chk($sformatf("%s.post_rdy", tg), in_ready[s], 1);
        chk($sformatf("%s.post_busy", tg), busy[s], 0);
        chk($sformatf("%s.post_en", tg), dp_en[s], 0);
        chk($sformatf("%s.post_done", tg), done[s], 0);
        return;
      end
    end
    for (int c = 0; c < stall + 8; c++) begin
      tick;
      in_valid[s] = 1'b1;
      j = c - stall;
      if (c < stall) begin
        out_ready[s] = 1'b0;
        #1;
        chk($sformatf("%s.st_ov%0d", tg, c), out_valid[s], 1);
        chk($sformatf("%s.st_en%0d", tg, c), dp_en[s], 0);
        chk($sformatf("%s.st_sh%0d", tg, c), dp_shift[s], 0);
        chk($sformatf("%s.st_dat%0d", tg, c), out_data[s], exp[3:0]);
        chk($sformatf("%s.st_rdy%0d", tg, c), in_ready[s], 0);
      end else begin
        out_ready[s] = 1'b1;
        #1;
        chk($sformatf("%s.dr_ov%0d", tg, j), out_valid[s], 1);
        chk($sformatf("%s.dr_dat%0d", tg, j), out_data[s], exp[4*j +: 4]);
        chk($sformatf("%s.dr_en%0d", tg, j), dp_en[s], 1);
        chk($sformatf("%s.dr_sh%0d", tg, j), dp_shift[s], 1);
        chk($sformatf("%s.dr_din%0d", tg, j), dp_data_in[s], 0);
        chk($sformatf("%s.dr_rdy%0d", tg, j), in_ready[s], 0);
        chk($sformatf("%s.dr_done%0d", tg, j), done[s], 0);
      end
    end
    tick;
    out_ready[s] = 1'b0;
    in_valid[s]  = 1'b0;
    #1;
    chk($sformatf("%s.done", tg), done[s], 1);
    chk($sformatf("%s.idle_busy", tg), busy[s], 0);
    chk($sformatf("%s.idle_rdy", tg), in_ready[s], 1);
    chk($sformatf("%s.idle_ov", tg), out_valid[s], 0);
    tick;
    chk($sformatf("%s.done_clr", tg), done[s], 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    tick;
    in_valid = '1;
    out_ready = '1;
    #1;
    chk("rst.rdy0", in_ready[0], 0);
    chk("rst.en0", dp_en[0], 0);
    chk("rst.ov0", out_valid[0], 0);
    chk("rst.rdy1", in_ready[1], 0);
    chk("rst.en1", dp_en[1], 0);
    tick;
    in_valid  = '0;
    out_ready = '0;
    rst       = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("idle.rdy", in_ready[0], 1);
      chk("idle.busy", busy[0], 0);
      chk("idle.en", dp_en[0], 0);
      chk("idle.ov", out_valid[0], 0);
      chk("idle.done", done[0], 0);
      chk("idle.rdy1", in_ready[1], 1);
    end

    // Nibbles 0..F then 0..7 back to back.
    do_block(0, 32'h7654_3210, 64'h7654_3210_FEDC_BA98, 32, 1'b0, 0, -1, "b2b");
    do_block(0, $urandom, {$urandom, $urandom}, 32, 1'b1, 0, -1, "tog");
    do_block(0, 32'h0, 64'h0, 32, 1'b0, 5, -1, "zero");
    for (int b = 0; b < 3; b++) begin
      do_block(0, $urandom, {$urandom, $urandom}, 32, 1'b0, b, -1, $sformatf("r32_%0d", b));
      do_block(1, $urandom, {$urandom, $urandom}, 1, b[0], 0, -1, $sformatf("r1_%0d", b));
    end
    do_block(0, $urandom, {$urandom, $urandom}, 32, 1'b0, 0, 10, "abort");
    do_block(0, 32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 32, 1'b0, 0, -1, "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
